// File: rtl/rollingsum_discr.sv
// Threshold discriminator on a rolling-sum stream: fires a one-cycle trigger on a
// crossing, tracks peak and time-over-threshold, then waits out a holdoff before re-arming.
module rollingsum_discr (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [18:0] sum_in,
   input  logic        sum_valid,
   input  logic        enable,
   input  logic [18:0] thresh,
   input  logic [18:0] hyst,
   input  logic [15:0] holdoff_len,
   output logic        trig_out,
   output logic [18:0] peak_out,
   output logic [15:0] tot_out,
   output logic        peak_valid
);

   typedef enum logic [1:0] {StIdle, StArmed, StOver, StHoldoff} state_e;

   state_e      state_q, state_d;
   logic [18:0] peak_q, peak_d;
   logic [15:0] tot_q, tot_d;
   logic [15:0] cnt_q, cnt_d;
   logic        trig_q, trig_d;
   logic        pv_q, pv_d;
   logic [18:0] peak_out_q, peak_out_d;
   logic [15:0] tot_out_q, tot_out_d;
   logic [18:0] lower;

   // Re-arm level; clamps to zero rather than wrapping when hyst exceeds thresh.
   assign lower = (hyst > thresh) ? 19'd0 : (thresh - hyst);

   always_comb begin
      state_d    = state_q;
      peak_d     = peak_q;
      tot_d      = tot_q;
      cnt_d      = cnt_q;
      trig_d     = 1'b0;
      pv_d       = 1'b0;
      peak_out_d = peak_out_q;
      tot_out_d  = tot_out_q;
      if (!enable) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               state_d = StArmed;
            end
            StArmed: begin
               if (sum_valid && (sum_in >= thresh)) begin
                  trig_d  = 1'b1;
                  peak_d  = sum_in;
                  tot_d   = 16'd1;
                  state_d = StOver;
               end
            end
            StOver: begin
               if (sum_valid) begin
                  if (sum_in >= lower) begin
                     if (sum_in > peak_q) begin
                        peak_d = sum_in;
                     end
                     if (tot_q != 16'hFFFF) begin
                        tot_d = tot_q + 16'd1;
                     end
                  end else begin
                     pv_d       = 1'b1;
                     peak_out_d = peak_q;
                     tot_out_d  = tot_q;
                     if (holdoff_len == 16'd0) begin
                        state_d = StArmed;
                     end else begin
                        state_d = StHoldoff;
                        cnt_d   = holdoff_len;
                     end
                  end
               end
            end
            StHoldoff: begin
               // The counter holds the cycles still to spend here, including this one.
               if (cnt_q <= 16'd1) begin
                  cnt_d   = 16'd0;
                  state_d = StArmed;
               end else begin
                  cnt_d = cnt_q - 16'd1;
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         peak_q     <= 19'd0;
         tot_q      <= 16'd0;
         cnt_q      <= 16'd0;
         trig_q     <= 1'b0;
         pv_q       <= 1'b0;
         peak_out_q <= 19'd0;
         tot_out_q  <= 16'd0;
      end else begin
         state_q    <= state_d;
         peak_q     <= peak_d;
         tot_q      <= tot_d;
         cnt_q      <= cnt_d;
         trig_q     <= trig_d;
         pv_q       <= pv_d;
         peak_out_q <= peak_out_d;
         tot_out_q  <= tot_out_d;
      end
   end

   assign trig_out   = trig_q;
   assign peak_valid = pv_q;
   assign peak_out   = peak_out_q;
   assign tot_out    = tot_out_q;

endmodule

// File: tb/tb_rollingsum_discr.sv
// Bench for rollingsum_discr: directed vector table and corner sequences, then random
// stimulus, all cross-checked every cycle against an episode-level reference model.
module tb_rollingsum_discr;

   logic        clk;
   logic        rst_n;
   logic [18:0] sum_in;
   logic        sum_valid;
   logic        enable;
   logic [18:0] thresh;
   logic [18:0] hyst;
   logic [15:0] holdoff_len;
   logic        trig_out;
   logic [18:0] peak_out;
   logic [15:0] tot_out;
   logic        peak_valid;

   rollingsum_discr dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sum_in      (sum_in),
      .sum_valid   (sum_valid),
      .enable      (enable),
      .thresh      (thresh),
      .hyst        (hyst),
      .holdoff_len (holdoff_len),
      .trig_out    (trig_out),
      .peak_out    (peak_out),
      .tot_out     (tot_out),
      .peak_valid  (peak_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int n_checks = 0;
   int cyc = 0;

   // Reference model: phase of the discriminator, with holdoff tracked as an absolute
   // re-arm time instead of a countdown.
   localparam int MIdle = 0, MArmed = 1, MOver = 2, MHold = 3;
   int m_phase = MIdle;
   int m_peak = 0, m_tot = 0, m_po = 0, m_to = 0, m_rearm = 0;
   bit m_trig = 0, m_pv = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic model_step();
      int lower;
      m_trig = 0;
      m_pv   = 0;
      if (!rst_n) begin
         m_phase = MIdle;
         m_peak  = 0;
         m_tot   = 0;
         m_po    = 0;
         m_to    = 0;
      end else if (!enable) begin
         m_phase = MIdle;
      end else begin
         case (m_phase)
            MIdle: m_phase = MArmed;
            MArmed: begin
               if (sum_valid && int'(sum_in) >= int'(thresh)) begin
                  m_trig  = 1;
                  m_peak  = int'(sum_in);
                  m_tot   = 1;
                  m_phase = MOver;
               end
            end
            MOver: begin
               lower = int'(thresh) - int'(hyst);
               if (lower < 0) lower = 0;
               if (sum_valid) begin
                  if (int'(sum_in) >= lower) begin
                     if (int'(sum_in) > m_peak) m_peak = int'(sum_in);
                     if (m_tot < 65535) m_tot = m_tot + 1;
                  end else begin
                     m_pv = 1;
                     m_po = m_peak;
                     m_to = m_tot;
                     if (holdoff_len == 0) m_phase = MArmed;
                     else begin
                        m_phase = MHold;
                        m_rearm = cyc + int'(holdoff_len);
                     end
                  end
               end
            end
            default: if (cyc >= m_rearm) m_phase = MArmed;
         endcase
      end
   endtask

   // One clock: predict, let the edge pass, compare away from the edge.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("trig_out", trig_out, m_trig);
      check("peak_valid", peak_valid, m_pv);
      check("peak_out", peak_out, m_po);
      check("tot_out", tot_out, m_to);
      cyc++;
   endtask

   task automatic drive(input bit v, input int s);
      sum_valid = v;
      sum_in    = s[18:0];
      tick();
   endtask

   typedef struct {
      bit v;
      int s;
      bit trig;
      bit pv;
      int peak;
      int tot;
   } vec_t;

   vec_t vecs[14];

   initial begin
      vecs[0]  = '{1, 50, 0, 0, 0, 0};
      vecs[1]  = '{1, 120, 1, 0, 0, 0};
      vecs[2]  = '{1, 200, 0, 0, 0, 0};
      vecs[3]  = '{1, 150, 0, 0, 0, 0};
      vecs[4]  = '{1, 95, 0, 0, 0, 0};
      vecs[5]  = '{1, 80, 0, 1, 200, 4};
      vecs[6]  = '{0, 0, 0, 0, 200, 4};
      vecs[7]  = '{0, 0, 0, 0, 200, 4};
      vecs[8]  = '{1, 300, 0, 0, 200, 4};
      vecs[9]  = '{0, 0, 0, 0, 200, 4};
      vecs[10] = '{0, 0, 0, 0, 200, 4};
      vecs[11] = '{0, 0, 0, 0, 200, 4};
      vecs[12] = '{1, 300, 1, 0, 200, 4};
      vecs[13] = '{1, 50, 0, 1, 300, 1};

      rst_n       = 1'b0;
      enable      = 1'b0;
      sum_valid   = 1'b0;
      sum_in      = '0;
      thresh      = 19'd100;
      hyst        = 19'd10;
      holdoff_len = 16'd4;
      tick();
      tick();
      check("reset_trig", trig_out, 0);
      check("reset_pv", peak_valid, 0);
      check("reset_peak", peak_out, 0);
      check("reset_tot", tot_out, 0);

      rst_n  = 1'b1;
      enable = 1'b1;
      drive(0, 0);

      // Basic pulse and holdoff window
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].v, vecs[i].s);
         check("vec_trig", trig_out, vecs[i].trig);
         check("vec_pv", peak_valid, vecs[i].pv);
         check("vec_peak", peak_out, vecs[i].peak);
         check("vec_tot", tot_out, vecs[i].tot);
      end

      // Invalid samples inside a pulse are neither counted nor peak-tracked
      repeat (5) drive(0, 0);
      drive(1, 150);
      check("gap_trig", trig_out, 1);
      drive(0, 500);
      drive(1, 110);
      drive(0, 0);
      drive(1, 120);
      drive(0, 999);
      drive(1, 10);
      check("gap_pv", peak_valid, 1);
      check("gap_peak", peak_out, 150);
      check("gap_tot", tot_out, 3);

      // Time-over-threshold saturation
      repeat (5) drive(0, 0);
      drive(1, 200);
      check("sat_trig", trig_out, 1);
      repeat (69999) drive(1, 200);
      drive(1, 0);
      check("sat_pv", peak_valid, 1);
      check("sat_tot", tot_out, 16'hFFFF);
      check("sat_peak", peak_out, 200);

      // Hysteresis clamp: lower level is 0 so the pulse never closes
      repeat (5) drive(0, 0);
      thresh = 19'd5;
      hyst   = 19'd20;
      drive(1, 10);
      check("clamp_trig", trig_out, 1);
      for (int i = 0; i < 20; i++) begin
         drive(1, (i % 3 == 0) ? 0 : 3);
         check("clamp_no_pv", peak_valid, 0);
      end
      enable = 1'b0;
      drive(1, 0);
      check("disable_pv", peak_valid, 0);
      drive(1, 0);
      check("idle_trig", trig_out, 0);
      check("idle_pv", peak_valid, 0);
      enable = 1'b1;
      drive(0, 0);

      // Zero holdoff re-arms at once; zero threshold crosses on any valid sample
      thresh      = 19'd100;
      hyst        = 19'd10;
      holdoff_len = 16'd0;
      drive(1, 150);
      check("zh_trig", trig_out, 1);
      drive(1, 5);
      check("zh_pv", peak_valid, 1);
      check("zh_peak", peak_out, 150);
      check("zh_tot", tot_out, 1);
      thresh = 19'd0;
      drive(1, 0);
      check("zt_trig", trig_out, 1);
      drive(1, 0);
      enable = 1'b0;
      drive(0, 0);
      thresh      = 19'd100;
      holdoff_len = 16'd4;
      enable      = 1'b1;
      drive(0, 0);

      // Reset in the middle of a pulse
      drive(1, 130);
      check("pre_rst_trig", trig_out, 1);
      drive(1, 160);
      rst_n = 1'b0;
      drive(1, 160);
      check("mid_rst_trig", trig_out, 0);
      check("mid_rst_pv", peak_valid, 0);
      check("mid_rst_peak", peak_out, 0);
      check("mid_rst_tot", tot_out, 0);
      rst_n = 1'b1;
      drive(0, 0);
      drive(1, 130);
      check("post_rst_trig", trig_out, 1);
      drive(1, 10);
      check("post_rst_pv", peak_valid, 1);
      check("post_rst_peak", peak_out, 130);
      check("post_rst_tot", tot_out, 1);

      // Random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         if (i % 200 == 0) begin
            thresh      = 19'($urandom_range(0, 300));
            hyst        = 19'($urandom_range(0, 120));
            holdoff_len = 16'($urandom_range(0, 6));
         end
         if (i % 37 == 0) holdoff_len = 16'($urandom_range(0, 6));
         rst_n  = ($urandom_range(0, 299) != 0);
         enable = ($urandom_range(0, 99) != 0);
         drive($urandom_range(0, 9) < 7, int'($urandom_range(0, 400)));
      end

      $display("Result: errors=%0d of %0d checks", errors, n_checks);
      $finish;
   end

endmodule
